// File: rtl/gray_to_binary_bm_if.sv
// Gray-to-binary converter bus: Gray source side (master) and converter side (slave).
// Latency: none; this is a signal bundle only.
// Backpressure: none; the source qualifies samples with in_valid and the converter always accepts.
interface gray_to_binary_bm_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] g;
  logic             in_valid;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_q;
  logic             out_valid;
  logic             step_err;
  logic             inc;
  logic             dec;

  // Gray-coded source: drives the code and its qualifier, observes the results.
  modport master (
    output g, in_valid,
    input  b, b_q, out_valid, step_err, inc, dec
  );

  // Converter: consumes the code, produces binary and step monitor flags.
  modport slave (
    input  g, in_valid,
    output b, b_q, out_valid, step_err, inc, dec
  );
endinterface

// File: rtl/gray_to_binary_bm.sv
// Gray-to-binary converter with a combinational path and a registered, step-monitored path.
// Latency: b is zero-cycle combinational; b_q and flags appear one clk after an accepted sample.
// Backpressure: none; every in_valid sample is accepted, flags are one-cycle pulses.
module gray_to_binary_bm #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_to_binary_bm_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Prefix XOR from the MSB down: each binary bit is the parity of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] gv);
    logic [WIDTH-1:0] r;
    r[WIDTH-1] = gv[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ gv[i];
    end
    return r;
  endfunction

  logic [WIDTH-1:0] conv_g;
  logic [WIDTH-1:0] gdiff;
  logic             one_bit_step;

  logic [WIDTH-1:0] bin_q,       bin_d;
  logic [WIDTH-1:0] g_prev_q,    g_prev_d;
  logic             has_prev_q,  has_prev_d;
  logic             out_valid_q, out_valid_d;
  logic             step_err_q,  step_err_d;
  logic             inc_q,       inc_d;
  logic             dec_q,       dec_d;

  // Combinational conversion and Hamming-distance-one test against the previous accepted code.
  always_comb begin
    conv_g       = gray2bin(bus.g);
    gdiff        = bus.g ^ g_prev_q;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    one_bit_step = (gdiff != '0) && ((gdiff & (gdiff - ONE)) == '0);
  end

  // Next-state: capture on accept, otherwise hold history and drop the pulses.
  always_comb begin
    bin_d       = bin_q;
    g_prev_d    = g_prev_q;
    has_prev_d  = has_prev_q;
    out_valid_d = 1'b0;
    step_err_d  = 1'b0;
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    if (bus.in_valid) begin
      bin_d       = conv_g;
      g_prev_d    = bus.g;
      has_prev_d  = 1'b1;
      out_valid_d = 1'b1;
      // The first sample after reset has nothing to compare against, so it never flags.
      if (has_prev_q) begin
        step_err_d = ~one_bit_step;
        inc_d      = (conv_g == bin_q + ONE);
        dec_d      = (conv_g == bin_q - ONE);
      end
    end
  end

  // State registers; reset clears history so the next accept is treated as the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      g_prev_q    <= '0;
      has_prev_q  <= 1'b0;
      out_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      g_prev_q    <= g_prev_d;
      has_prev_q  <= has_prev_d;
      out_valid_q <= out_valid_d;
      step_err_q  <= step_err_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
    end
  end

  assign bus.b         = conv_g;
  assign bus.b_q       = bin_q;
  assign bus.out_valid = out_valid_q;
  assign bus.step_err  = step_err_q;
  assign bus.inc       = inc_q;
  assign bus.dec       = dec_q;

endmodule

// File: tb/tb_gray_to_binary_bm.sv
// Bench for gray_to_binary_bm: directed scenarios plus random streams against a reference model.
// Latency: checks b immediately, registered outputs #1 after the accepting rising edge.
// Backpressure: none; the bench drives in_valid freely.
module tb_gray_to_binary_bm;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic clk;
  logic clk_en;
  logic rst_n;
  int   total;
  int   bad;

  gray_to_binary_bm_if #(.WIDTH(W)) bus ();

  gray_to_binary_bm #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock only toggles when enabled so the combinational sweep runs with clk idle.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference model state (plain integers, not the RTL's encoding).
  int         m_gprev;
  int         m_bq;
  bit         m_has;
  logic [W-1:0] exp_bq;
  logic       exp_ov, exp_se, exp_inc, exp_dec;

  // Binary value whose Gray encoding n ^ (n >> 1) equals gv, found by search.
  function automatic int ref_bin(input int gv);
    for (int n = 0; n < M; n++) begin
      if ((n ^ (n >> 1)) == gv) return n;
    end
    return -1;
  endfunction

  function automatic int popcnt(input int x);
    int c;
    c = 0;
    for (int k = 0; k < W; k++) c += (x >> k) & 1;
    return c;
  endfunction

  task automatic model_reset();
    m_gprev = 0; m_bq = 0; m_has = 0;
    exp_bq = '0; exp_ov = 0; exp_se = 0; exp_inc = 0; exp_dec = 0;
  endtask

  // Present one sample (or idle) at the falling edge, let the rising edge take it, update the model.
  task automatic drive(input logic [W-1:0] gv, input logic vld);
    int nb;
    @(negedge clk);
    bus.g = gv;
    bus.in_valid = vld;
    @(posedge clk);
    if (vld) begin
      nb = ref_bin(int'(gv));
      if (m_has) begin
        exp_se  = (popcnt(int'(gv) ^ m_gprev) != 1);
        exp_inc = (nb == (m_bq + 1) % M);
        exp_dec = (nb == (m_bq + M - 1) % M);
      end else begin
        exp_se = 0; exp_inc = 0; exp_dec = 0;
      end
      exp_ov  = 1;
      m_bq    = nb;
      m_gprev = int'(gv);
      m_has   = 1;
      exp_bq  = nb[W-1:0];
    end else begin
      exp_ov = 0; exp_se = 0; exp_inc = 0; exp_dec = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (bus.b_q !== 4'b0000) begin
      bad++; $display("FAIL reset_bq actual=%b required=0000", bus.b_q);
    end
    total++;
    if ({bus.out_valid, bus.step_err, bus.inc, bus.dec} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags actual=%b required=0000",
                      {bus.out_valid, bus.step_err, bus.inc, bus.dec});
    end
  endtask

  task automatic test_comb_sweep();
    logic [W-1:0] eb;
    for (int k = 0; k <= M; k++) begin
      bus.g = k[W-1:0];
      #20;
      eb = ref_bin(k % M);
      total++;
      if (bus.b !== eb) begin
        bad++; $display("FAIL comb_sweep g=%b actual=%b required=%b", bus.g, bus.b, eb);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(4'b1111, 1'b1);
    total++;
    if (bus.b_q !== 4'b1010) begin
      bad++; $display("FAIL pre_reset_bq actual=%b required=1010", bus.b_q);
    end
    #2;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.b_q, bus.out_valid, bus.step_err, bus.inc, bus.dec} !== 8'b0000_0000) begin
      bad++; $display("FAIL async_reset actual=%b required=00000000",
                      {bus.b_q, bus.out_valid, bus.step_err, bus.inc, bus.dec});
    end
    total++;
    if (bus.b !== 4'b1010) begin
      bad++; $display("FAIL reset_b_tracks actual=%b required=1010", bus.b);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0110, 1'b1);
    total++;
    if ({bus.b_q, bus.out_valid, bus.step_err, bus.inc, bus.dec} !== 8'b0100_1000) begin
      bad++; $display("FAIL first_after_reset actual=%b required=01001000",
                      {bus.b_q, bus.out_valid, bus.step_err, bus.inc, bus.dec});
    end
  endtask

  task automatic test_up_count();
    int gc;
    for (int k = 0; k <= M; k++) begin
      gc = (k % M) ^ ((k % M) >> 1);
      drive(gc[W-1:0], 1'b1);
      total++;
      if ({bus.b_q, bus.out_valid, bus.step_err, bus.inc, bus.dec} !==
          {exp_bq, exp_ov, exp_se, exp_inc, exp_dec}) begin
        bad++; $display("FAIL up_count_model k=%0d actual=%b required=%b", k,
                        {bus.b_q, bus.out_valid, bus.step_err, bus.inc, bus.dec},
                        {exp_bq, exp_ov, exp_se, exp_inc, exp_dec});
      end
      if (k > 0) begin
        total++;
        if ({bus.inc, bus.step_err, bus.dec} !== 3'b100) begin
          bad++; $display("FAIL up_count_inc k=%0d actual=%b required=100", k,
                          {bus.inc, bus.step_err, bus.dec});
        end
      end
    end
  endtask

  task automatic test_down();
    drive(4'b0000, 1'b1);
    drive(4'b1000, 1'b1);
    total++;
    if ({bus.b_q, bus.dec, bus.step_err, bus.inc} !== 7'b1111_100) begin
      bad++; $display("FAIL down_wrap actual=%b required=1111100",
                      {bus.b_q, bus.dec, bus.step_err, bus.inc});
    end
  endtask

  task automatic test_illegal();
    drive(4'b0001, 1'b1);
    drive(4'b0110, 1'b1);
    total++;
    if ({bus.b_q, bus.step_err, bus.inc, bus.dec} !== 7'b0100_100) begin
      bad++; $display("FAIL illegal_step actual=%b required=0100100",
                      {bus.b_q, bus.step_err, bus.inc, bus.dec});
    end
  endtask

  task automatic test_gaps();
    drive(4'b0011, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(4'b1100, 1'b0);
      total++;
      if ({bus.b_q, bus.out_valid} !== 5'b0010_0) begin
        bad++; $display("FAIL gap_hold k=%0d actual=%b required=00100", k,
                        {bus.b_q, bus.out_valid});
      end
    end
    drive(4'b0010, 1'b1);
    total++;
    if ({bus.out_valid, bus.inc, bus.step_err} !== 3'b110) begin
      bad++; $display("FAIL gap_resume actual=%b required=110",
                      {bus.out_valid, bus.inc, bus.step_err});
    end
    drive(4'b0010, 1'b1);
    total++;
    if ({bus.step_err, bus.inc, bus.dec} !== 3'b100) begin
      bad++; $display("FAIL repeat_sample actual=%b required=100",
                      {bus.step_err, bus.inc, bus.dec});
    end
  endtask

  task automatic test_back_to_back_random();
    logic [W-1:0] gv;
    logic         vld;
    int           pick;
    gv = '0;
    for (int n = 0; n < 300; n++) begin
      vld  = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 9);
      if (pick < 6)       gv = gv ^ (4'b0001 << $urandom_range(0, W - 1));
      else if (pick < 7)  gv = gv;
      else                gv = W'($urandom_range(0, M - 1));
      drive(gv, vld);
      total++;
      if ({bus.b_q, bus.out_valid, bus.step_err, bus.inc, bus.dec} !==
          {exp_bq, exp_ov, exp_se, exp_inc, exp_dec}) begin
        bad++; $display("FAIL random n=%0d g=%b vld=%b actual=%b required=%b", n, gv, vld,
                        {bus.b_q, bus.out_valid, bus.step_err, bus.inc, bus.dec},
                        {exp_bq, exp_ov, exp_se, exp_inc, exp_dec});
      end
      total++;
      if (bus.b !== W'(ref_bin(int'(gv)))) begin
        bad++; $display("FAIL random_comb n=%0d g=%b actual=%b", n, gv, bus.b);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    clk = 1'b0;
    clk_en = 1'b0;
    rst_n = 1'b0;
    bus.g = '0;
    bus.in_valid = 1'b0;
    model_reset();

    test_reset();
    test_comb_sweep();

    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    test_reset_mid();
    test_up_count();
    test_down();
    test_illegal();
    test_gaps();
    test_back_to_back_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_to_binary_bm.md
# gray_to_binary_bm

Gray-code to binary converter with a zero-latency combinational path and a registered, monitored path. It sits between Gray-coded sources (encoders, async-FIFO pointers, position counters) and binary consumers. Each registered sample is checked against the previous one to flag illegal multi-bit steps and to report count direction.

## Interface
- WIDTH, 4, code width in bits (≥2)
- clk  in  1  rising-edge clock for the registered path
- rst_n  in  1  asynchronous active-low reset
- g  in  WIDTH  Gray-coded input
- in_valid  in  1  qualifies g for capture on the next rising clk
- b  out  WIDTH  combinational binary equivalent of g
- b_q  out  WIDTH  registered binary of the last accepted g
- out_valid  out  1  high for the cycle after a sample is accepted
- step_err  out  1  accepted sample not exactly one Gray bit away from the previous accepted sample
- inc  out  1  accepted sample equals previous binary +1 (mod 2^WIDTH)
- dec  out  1  accepted sample equals previous binary −1 (mod 2^WIDTH)

## Operation
- Conversion: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0 (prefix XOR from MSB).
- b is purely combinational: no clock, no reset, no enable dependency. It is valid with clk idle.
- Accept: at a rising clk with in_valid=1, the block does all of the following:
  - b_q ← conv(g); g_prev ← g; out_valid ← 1.
  - If a previous accepted sample exists since reset (has_prev=1), compute h = popcount(g XOR g_prev):
    - step_err ← (h ≠ 1).
    - inc ← (conv(g) == b_q + 1 mod 2^WIDTH).
    - dec ← (conv(g) == b_q − 1 mod 2^WIDTH).
  - If has_prev=0, step_err, inc and dec ← 0.
  - has_prev ← 1.
- No accept (in_valid=0): out_valid, step_err, inc, dec ← 0; b_q, g_prev and has_prev hold.
- Repeated identical sample (h=0): step_err=1, inc=0, dec=0.
- Wrap-around: all-ones binary → 0 sets inc=1; 0 → all-ones binary sets dec=1. Neither is an error; the Gray codes differ in the MSB only.
- inc and dec are never both 1 (WIDTH ≥ 2).
- Internal state: g_prev[WIDTH-1:0], has_prev.

## Timing
- b: zero-cycle combinational latency from g.
- b_q, out_valid, step_err, inc, dec: one-cycle latency. They update on the rising clk that samples in_valid=1 and are registered outputs.
- Reset (rst_n=0, asynchronous, immediate):
  - b_q=0, out_valid=0, step_err=0, inc=0, dec=0.
  - g_prev=0, has_prev=0.
  - b keeps tracking g.
- Reset deassertion is synchronous to clk. The first accept after reset never flags step_err, inc or dec.
- Reset asserted mid-stream discards history. The next accepted sample is treated as first.
- Flag outputs are single-cycle pulses per accepted sample. Back-to-back accepts produce back-to-back results.

## Test plan
- Combinational sweep, no clock, WIDTH=4: g steps 0000→1111 every 20 ns, then wraps.
  - Required b: 0001→0001, 0010→0011, 0011→0010, 0100→0111, 0111→0101, 1000→1111, 1111→1010, wrap to 0000→0000.
- Reset: assert rst_n=0 mid-operation with b_q=1010 → b_q=0, all flags 0 immediately. The next accept of g=0110 gives b_q=0100, out_valid=1, step_err=0, inc=0, dec=0.
- Gray up-count: accept g = 0000, 0001, 0011, 0010, …, 1000, 0000 on consecutive cycles.
  - inc=1 and step_err=0 from the second sample onward, including the 1000→0000 wrap.
- Down-count: accept g=0000 then g=1000 → b_q=1111, dec=1, step_err=0.
- Illegal step: accept g=0001 then g=0110 (h=3) → step_err=1, inc=0, dec=0, b_q=0100.
- Gaps: accept g=0011, hold in_valid=0 for 3 cycles (out_valid=0, b_q stays 0010), then accept g=0010 → inc=1, step_err=0. Repeat g=0010 → step_err=1.
